fifo_uart_tx: RTL and testbench

Downstream drain stage for the 16-bit, 8-deep FIFO buffer. When the FIFO is non-empty, the block pops one word and transmits it on a single-wire 8N1 UART line as two bytes, low byte first. It then returns for the next word. It is the serial egress point of the data path.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/uart_bit_timer.sv | 30 +++
 rtl/fifo_uart_tx.sv | 124 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO drain / UART egress path.
package fifo_pkg;

  localparam int DATA_W     = 16;
  localparam int BYTE_W     = 8;
  // One start bit, eight data bits and one stop bit per byte on the line.
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter for the UART transmitter: counts 0..CLKS_PER_BIT-1 and
// flags the last cycle of each bit period with tick.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  // Wraps at the terminal count; restart realigns it to a new state's first cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains 16-bit words from the FIFO and sends each as two 8N1 UART bytes,
// low byte first. tx is registered so the line never glitches.
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              rd_en,
  output logic              tx,
  output logic              busy
);

  // Index of the final data bit in a byte.
  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 3);

  tx_state_t         state, state_next;
  logic [DATA_W-1:0] word, word_next;
  logic [2:0]        bit_idx, bit_idx_next;
  logic              byte_sel, byte_sel_next;
  logic [BYTE_W-1:0] cur_byte;
  logic              tx_next;
  logic              tick;
  logic              restart;

  // The baud counter starts fresh on every state change.
  assign restart = (state_next != state);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // State, word, bit position and line level all advance together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      word     <= '0;
      bit_idx  <= '0;
      byte_sel <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      word     <= word_next;
      bit_idx  <= bit_idx_next;
      byte_sel <= byte_sel_next;
      tx       <= tx_next;
    end
  end

  // Sequencing: pop, capture, then start/data/stop for each of the two bytes.
  always_comb begin
    state_next    = state;
    word_next     = word;
    bit_idx_next  = bit_idx;
    byte_sel_next = byte_sel;
    case (state)
      IDLE: begin
        if (enable && !empty) begin
          state_next = REQ;
        end
      end
      REQ: begin
        state_next = LOAD;
      end
      LOAD: begin
        word_next     = fifo_data;
        byte_sel_next = 1'b0;
        state_next    = START;
      end
      START: begin
        if (tick) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == LAST_BIT) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (!byte_sel) begin
            byte_sel_next = 1'b1;
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, derived from where the FSM is heading.
  always_comb begin
    cur_byte = byte_sel_next ? word_next[DATA_W-1:BYTE_W] : word_next[BYTE_W-1:0];
    tx_next  = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_idx_next];
      default: tx_next = 1'b1;
    endcase
  end

  assign rd_en = (state == REQ);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: three instances (4, 2 and 16 clocks
// per bit) share one FIFO model; only the selected instance sees a non-empty
// FIFO. A cycle-level reference schedule predicts rd_en, busy and tx.
module tb_fifo_uart_tx;

  localparam int CPB_TAB [3] = '{4, 2, 16};

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        empty = 1'b1;
  logic [15:0] fifo_data = 16'hDEAD;
  int          sel;

  logic [2:0]  empty_v;
  logic [2:0]  rd_en_v;
  logic [2:0]  tx_v;
  logic [2:0]  busy_v;

  logic [15:0] fifo_q [$];
  logic [15:0] exp_words [$];
  logic [2:0]  sched [$];

  int          n_vectors = 0;
  int          n_miscompares = 0;
  int          pops = 0;
  logic        rd_seen = 1'b0;
  int          busy_run = 0;
  int          last_busy = 0;
  int          cyc = 0;
  int          last_pop = 0;
  int          pop_gap = 0;
  logic [2:0]  exp_now;
  int          p0;
  int          n;
  logic [15:0] rnd_word;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign empty_v[g] = empty || (sel != g);
    fifo_uart_tx #(
      .CLKS_PER_BIT(CPB_TAB[g])
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .enable   (enable),
      .empty    (empty_v[g]),
      .fifo_data(fifo_data),
      .rd_en    (rd_en_v[g]),
      .tx       (tx_v[g]),
      .busy     (busy_v[g])
    );
  end

  // Counts every comparison and reports the ones that disagree.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Sets enable just after a rising edge and lets the given number of cycles pass.
  task automatic applyStimulus(input logic en, input int cycles);
    enable = en;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_words.push_back(w);
  endtask

  // Expected per-cycle {rd_en, busy, tx} for one word: pop cycle, load
  // cycle, then two 10-bit frames with each bit held for cpb cycles.
  function automatic void buildFrame(input logic [15:0] w, input int cpb);
    logic [7:0] by;
    logic       bitv;
    sched.push_back(3'b111);
    sched.push_back(3'b011);
    for (int b = 0; b < 2; b++) begin
      by = (b == 0) ? w[7:0] : w[15:8];
      for (int k = 0; k < 10; k++) begin
        if (k == 0)      bitv = 1'b0;
        else if (k == 9) bitv = 1'b1;
        else             bitv = by[k-1];
        for (int c = 0; c < cpb; c++) sched.push_back({2'b01, bitv});
      end
    end
  endfunction

  // Registered FIFO: a pop seen in cycle N presents its word from cycle N+1.
  always @(posedge clk) begin
    if (rd_seen && fifo_q.size() > 0) begin
      fifo_data <= fifo_q.pop_front();
      pops      <= pops + 1;
    end
    empty <= (fifo_q.size() == 0);
  end

  // Reference model and output comparison, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      sched.delete();
      exp_now = 3'b001;
    end else if (sched.size() > 0) begin
      exp_now = sched.pop_front();
    end else begin
      exp_now = 3'b001;
    end
    checkOutput("rd_en", rd_en_v[sel], exp_now[2]);
    checkOutput("busy", busy_v[sel], exp_now[1]);
    checkOutput("tx", tx_v[sel], exp_now[0]);
    rd_seen = rd_en_v[sel];
    if (rd_en_v[sel]) begin
      pop_gap  = cyc - last_pop;
      last_pop = cyc;
    end
    if (busy_v[sel]) begin
      busy_run++;
    end else if (busy_run > 0) begin
      last_busy = busy_run;
      busy_run  = 0;
    end
    if (rst && !exp_now[1] && enable && !empty_v[sel]) begin
      if (exp_words.size() == 0) begin
        checkOutput("model_words", 0, 1);
      end else begin
        buildFrame(exp_words.pop_front(), CPB_TAB[sel]);
      end
    end
  end

  initial begin
    rst    = 1'b0;
    enable = 1'b1;
    sel    = 0;

    // Reset held with data waiting, then single word 0xA53C.
    pushWord(16'hA53C);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tx", tx_v[0], 1'b1);
    checkOutput("rst_rd_en", rd_en_v[0], 1'b0);
    checkOutput("rst_busy", busy_v[0], 1'b0);
    p0  = pops;
    rst = 1'b1;
    applyStimulus(1'b1, 100);
    checkOutput("single_pops", pops - p0, 1);
    checkOutput("single_busy_len", last_busy, 82);

    // Drain three words to empty.
    p0 = pops;
    pushWord(16'h0012);
    pushWord(16'h0022);
    pushWord(16'h0032);
    applyStimulus(1'b1, 270);
    checkOutput("drain_pops", pops - p0, 3);
    checkOutput("drain_pop_gap", pop_gap, 83);
    checkOutput("drain_busy", busy_v[0], 1'b0);

    // Enable dropped during the first data bit of 0x1234.
    p0 = pops;
    pushWord(16'h1234);
    applyStimulus(1'b1, 9);
    pushWord(16'h5678);
    applyStimulus(1'b0, 120);
    checkOutput("hold_pops", pops - p0, 1);
    checkOutput("hold_words", fifo_q.size(), 1);
    checkOutput("hold_busy", busy_v[0], 1'b0);
    applyStimulus(1'b1, 100);

    // Reset in the middle of the first byte, with another word queued.
    p0 = pops;
    pushWord(16'h9ABC);
    pushWord(16'hBEEF);
    applyStimulus(1'b1, 14);
    rst = 1'b0;
    #1;
    checkOutput("midrst_tx", tx_v[0], 1'b1);
    checkOutput("midrst_busy", busy_v[0], 1'b0);
    checkOutput("midrst_rd_en", rd_en_v[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 100);
    checkOutput("midrst_pops", pops - p0, 2);

    // Random words with random enable gating.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        rnd_word = 16'($urandom);
        pushWord(rnd_word);
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(20, 150));
    end
    applyStimulus(1'b1, fifo_q.size() * 83 + 120);
    checkOutput("rand_fifo_drained", fifo_q.size(), 0);
    checkOutput("rand_model_drained", exp_words.size(), 0);

    // Parameter sweep: 2 and 16 clocks per bit.
    sel = 1;
    p0  = pops;
    pushWord(16'hA53C);
    applyStimulus(1'b1, 60);
    checkOutput("cpb2_pops", pops - p0, 1);
    checkOutput("cpb2_busy_len", last_busy, 42);

    sel = 2;
    p0  = pops;
    pushWord(16'hA53C);
    applyStimulus(1'b1, 340);
    checkOutput("cpb16_pops", pops - p0, 1);
    checkOutput("cpb16_busy_len", last_busy, 322);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
